// File: rtl/serial_op_pkg.sv
// Shared constants for the serial operand controller: FSM encoding,
// default transaction lengths and a small width helper.
`timescale 1ns/1ps
package serial_op_pkg;

   // FSM state encoding
   localparam logic [1:0] WAIT_B = 2'd0;
   localparam logic [1:0] WAIT_A = 2'd1;
   localparam logic [1:0] TAKE_A = 2'd2;
   localparam logic [1:0] SEND_C = 2'd3;

   // Default transaction lengths
   localparam int A_LEN_DEF = 4;
   localparam int C_LEN_DEF = 3;

   // Larger of two lengths, used to size the shared cycle counter
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sop_cycle_cnt.sv
// Loadable / clearable up-counter with a terminal-value compare flag.
// The terminal value is an input so one counter can serve phases of
// different lengths.
`timescale 1ns/1ps
module sop_cycle_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_inc,
   input  logic [W-1:0] i_term,
   output logic         o_term
);

   logic [W-1:0] r_cnt;

   // Counter update: clear beats load beats increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_term = (r_cnt == i_term);

endmodule

// File: rtl/serial_op_ctrl.sv
// Serial operand controller: latches B, shifts A in for A_LEN cycles,
// latches the result, then shifts C out for C_LEN cycles. Every output is
// registered and decided on the same edge as the state update.
`timescale 1ns/1ps
module serial_op_ctrl
   import serial_op_pkg::*;
#(
   parameter int A_LEN   = A_LEN_DEF,
   parameter int C_LEN   = C_LEN_DEF,
   parameter bit REUSE_B = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic load_b,
   input  logic start_a,
   input  logic abort,
   output logic latch_b,
   output logic shift_a,
   output logic latch_c,
   output logic start_c,
   output logic shift_c,
   output logic busy,
   output logic done,
   output logic overrun
);

   localparam int CW = $clog2(max_int(A_LEN, C_LEN) + 1);
   // TAKE_A ends when the count reaches A_LEN-1 (entry cycle is count 0).
   localparam logic [CW-1:0] A_TERM = CW'(A_LEN - 1);
   // The first shift_c is issued off latch_c without counting, so the
   // remaining shift_c cycles terminate one count earlier.
   localparam logic [CW-1:0] C_TERM = CW'((C_LEN > 1) ? C_LEN - 2 : 0);
   localparam logic [1:0]    END_ST = REUSE_B ? WAIT_A : WAIT_B;

   logic [1:0]    r_state, w_state_nx;
   logic          r_latch_b, r_shift_a, r_latch_c, r_start_c;
   logic          r_shift_c, r_busy, r_done, r_overrun;
   logic          w_latch_b, w_shift_a, w_latch_c, w_start_c;
   logic          w_shift_c, w_busy, w_done, w_overrun;
   logic          w_cnt_clr, w_cnt_inc, w_cnt_term;
   logic [CW-1:0] w_cnt_tval;

   assign w_cnt_tval = (r_state == TAKE_A) ? A_TERM : C_TERM;

   sop_cycle_cnt #(.W(CW)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (w_cnt_clr),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_inc      (w_cnt_inc),
      .i_term     (w_cnt_tval),
      .o_term     (w_cnt_term)
   );

   // Next-state and next-output decision; abort overrides everything
   always_comb begin
      w_state_nx = r_state;
      w_latch_b  = 1'b0;
      w_shift_a  = 1'b0;
      w_latch_c  = 1'b0;
      w_start_c  = 1'b0;
      w_shift_c  = 1'b0;
      w_done     = 1'b0;
      w_overrun  = 1'b0;
      w_cnt_clr  = 1'b0;
      w_cnt_inc  = 1'b0;
      if (abort) begin
         w_state_nx = WAIT_B;
         w_cnt_clr  = 1'b1;
      end else begin
         case (r_state)
            WAIT_B: begin
               if (load_b) begin
                  w_latch_b  = 1'b1;
                  w_state_nx = WAIT_A;
               end
            end
            WAIT_A: begin
               // load_b wins a tie; start_a is simply dropped then
               if (load_b) begin
                  w_latch_b = 1'b1;
               end else if (start_a) begin
                  w_shift_a  = 1'b1;
                  w_cnt_clr  = 1'b1;
                  w_state_nx = TAKE_A;
               end
            end
            TAKE_A: begin
               w_overrun = start_a;
               if (w_cnt_term) begin
                  w_latch_c  = 1'b1;
                  w_cnt_clr  = 1'b1;
                  w_state_nx = SEND_C;
               end else begin
                  w_shift_a = 1'b1;
                  w_cnt_inc = 1'b1;
               end
            end
            SEND_C: begin
               w_overrun = start_a;
               if (r_latch_c) begin
                  w_shift_c = 1'b1;
                  w_start_c = 1'b1;
                  w_done    = (C_LEN == 1);
               end else if (r_done) begin
                  w_state_nx = END_ST;
                  w_cnt_clr  = 1'b1;
               end else begin
                  w_shift_c = 1'b1;
                  w_cnt_inc = 1'b1;
                  w_done    = w_cnt_term;
               end
            end
            default: begin
               w_state_nx = WAIT_B;
               w_cnt_clr  = 1'b1;
            end
         endcase
      end
      w_busy = (w_state_nx == TAKE_A) || (w_state_nx == SEND_C);
   end

   // State and output registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= WAIT_B;
         r_latch_b <= 1'b0;
         r_shift_a <= 1'b0;
         r_latch_c <= 1'b0;
         r_start_c <= 1'b0;
         r_shift_c <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_latch_b <= w_latch_b;
         r_shift_a <= w_shift_a;
         r_latch_c <= w_latch_c;
         r_start_c <= w_start_c;
         r_shift_c <= w_shift_c;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_overrun <= w_overrun;
      end
   end

   assign latch_b = r_latch_b;
   assign shift_a = r_shift_a;
   assign latch_c = r_latch_c;
   assign start_c = r_start_c;
   assign shift_c = r_shift_c;
   assign busy    = r_busy;
   assign done    = r_done;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_serial_op_ctrl.sv
// Bench for serial_op_ctrl: two instances (default lengths with B reload,
// and A_LEN=8/C_LEN=5 with B reuse) share one stimulus stream. A
// transaction-offset reference model predicts every output cycle into a
// per-instance queue; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_serial_op_ctrl;
   import serial_op_pkg::*;

   localparam int A0 = A_LEN_DEF;
   localparam int C0 = C_LEN_DEF;
   localparam bit R0 = 1'b0;
   localparam int A1 = 8;
   localparam int C1 = 5;
   localparam bit R1 = 1'b1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic load_b = 1'b0, start_a = 1'b0, abort = 1'b0;

   logic lb0, sa0, lc0, sc0, shc0, bz0, dn0, ov0;
   logic lb1, sa1, lc1, sc1, shc1, bz1, dn1, ov1;
   logic [7:0] out0, out1;
   // bit order: overrun, done, busy, shift_c, start_c, latch_c, shift_a, latch_b
   assign out0 = {ov0, dn0, bz0, shc0, sc0, lc0, sa0, lb0};
   assign out1 = {ov1, dn1, bz1, shc1, sc1, lc1, sa1, lb1};

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic [7:0] m0, m1;

   // model state: transaction active, B held, offset of current cycle
   bit act[2];
   bit hb[2];
   int off[2];

   always #5 clk = ~clk;

   serial_op_ctrl #(.A_LEN(A0), .C_LEN(C0), .REUSE_B(R0)) u_dut0 (
      .clk(clk), .reset(reset), .load_b(load_b), .start_a(start_a), .abort(abort),
      .latch_b(lb0), .shift_a(sa0), .latch_c(lc0), .start_c(sc0), .shift_c(shc0),
      .busy(bz0), .done(dn0), .overrun(ov0));

   serial_op_ctrl #(.A_LEN(A1), .C_LEN(C1), .REUSE_B(R1)) u_dut1 (
      .clk(clk), .reset(reset), .load_b(load_b), .start_a(start_a), .abort(abort),
      .latch_b(lb1), .shift_a(sa1), .latch_c(lc1), .start_c(sc1), .shift_c(shc1),
      .busy(bz1), .done(dn1), .overrun(ov1));

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
      end
   endtask

   // Transaction view: offsets 0..a-1 shift A, a latches C,
   // a+1..a+c shift C (first = start_c, last = done); busy throughout.
   task automatic model_step(input int d, input int a, input int c, input bit r,
                             output logic [7:0] v);
      v = '0;
      if (abort) begin
         act[d] = 1'b0;
         hb[d]  = 1'b0;
      end else if (act[d]) begin
         v[7] = start_a;
         off[d]++;
         if (off[d] > a + c) begin
            act[d] = 1'b0;
            hb[d]  = r;
         end
      end else if (load_b) begin
         v[0]  = 1'b1;
         hb[d] = 1'b1;
      end else if (hb[d] && start_a) begin
         act[d] = 1'b1;
         off[d] = 0;
      end
      if (act[d]) begin
         v[1] = (off[d] < a);
         v[2] = (off[d] == a);
         v[3] = (off[d] == a + 1);
         v[4] = (off[d] > a);
         v[5] = 1'b1;
         v[6] = (off[d] == a + c);
      end
   endtask

   // One clock: predict outputs for the edge just taken, then drive new inputs
   task automatic cyc(input logic lb, input logic sa, input logic ab);
      logic [7:0] v;
      @(posedge clk);
      #2;
      model_step(0, A0, C0, R0, v);
      q0.push_back(v);
      model_step(1, A1, C1, R1, v);
      q1.push_back(v);
      mon_en  = 1'b1;
      load_b  = lb;
      start_a = sa;
      abort   = ab;
   endtask

   // Assert reset between edges, confirm outputs clear without a clock
   task automatic do_reset();
      #1;
      mon_en  = 1'b0;
      load_b  = 1'b0;
      start_a = 1'b0;
      abort   = 1'b0;
      reset   = 1'b0;
      #1;
      chk("reset dut0", out0, 8'h00);
      chk("reset dut1", out1, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0;
         hb[i]  = 1'b0;
         off[i] = 0;
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (q0.size() == 0 || q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard at %0t: got empty queue expected entry", $time);
         end else begin
            m0 = q0.pop_front();
            m1 = q1.pop_front();
            chk("dut0 outputs", out0, m0);
            chk("dut1 outputs", out1, m1);
         end
      end
   end

   initial begin
      bit found;
      do_reset();

      // basic timeline: load_b, idle, start_a
      cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0);
      repeat (12) cyc(0, 0, 0);

      // start_a without B on the reload instance
      cyc(0, 1, 0);
      repeat (20) cyc(0, 0, 0);

      // back-to-back transactions reusing B
      cyc(0, 1, 0);
      repeat (15) cyc(0, 0, 0);
      cyc(0, 1, 0);
      repeat (16) cyc(0, 0, 0);

      // abort on second shift_a cycle, then reload
      cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 0, 1);
      repeat (4) cyc(0, 0, 0);
      cyc(1, 0, 0); cyc(0, 1, 0);
      repeat (16) cyc(0, 0, 0);

      // overrun during TAKE_A and SEND_C
      cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 1, 0);
      cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0);
      repeat (16) cyc(0, 0, 0);

      // both load_b and start_a together in WAIT_A
      cyc(1, 0, 0); cyc(1, 1, 0);
      repeat (16) cyc(0, 0, 0);

      // reset mid SEND_C, then start_a ignored until load_b
      cyc(1, 0, 0); cyc(0, 1, 0);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         cyc(0, 0, 0);
         if (act[0] && off[0] == A0 + 2) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL send_c wait: got timeout expected SEND_C within 30 cycles");
      end
      do_reset();
      cyc(0, 1, 0);
      repeat (5) cyc(0, 0, 0);
      cyc(1, 0, 0); cyc(0, 1, 0);
      repeat (16) cyc(0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(999) == 0) do_reset();
         cyc(($urandom_range(99) < 10), ($urandom_range(99) < 15), ($urandom_range(99) < 2));
      end
      repeat (20) cyc(0, 0, 0);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
